// File: rtl/prim_arb_pkg.sv
// Purpose: shared arbitration types and the round-robin pick helper.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
// Contents: arb_state_e lock-machine states, rr_pick_t pick result,
//           rr_pick() first-set scan starting at a rotating pointer, ARB_MAX_N.
package prim_arb_pkg;

    localparam int ARB_MAX_N = 16;
    localparam int ARB_IDX_W = $clog2(ARB_MAX_N);

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                 found;
        logic [ARB_IDX_W-1:0] idx;
    } rr_pick_t;

    // Scans req in the order ptr, ptr+1, ... wrapping at ARB_MAX_N. Callers with
    // fewer requesters zero-pad req, so the padded positions never win and the
    // effective wrap point is the caller's own N. The loop runs from the lowest
    // priority offset to the highest so the final assignment is the winner.
    function automatic rr_pick_t rr_pick(input logic [ARB_MAX_N-1:0] req,
                                         input logic [ARB_IDX_W-1:0] ptr);
        rr_pick_t             res;
        logic [ARB_IDX_W-1:0] idx;
        res = '0;
        for (int k = ARB_MAX_N - 1; k >= 0; k--) begin
            idx = ptr + ARB_IDX_W'(k);
            if (req[idx]) begin
                res.found = 1'b1;
                res.idx   = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/prim_fifo2.sv
// Purpose: 2-entry skid stage (primary + overflow) with registered output data.
// Latency: 1 cycle from write to rd_vld when not stalled.
// Backpressure: wr_rdy drops only once the overflow entry holds a beat; stall masks rd_vld.
// Ports: clk, reset (sync, active-high); wr_vld/wr_dat/wr_rdy upstream;
//        stall, rd_rdy, rd_vld, rd_dat downstream.
module prim_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             wr_rdy,
    input  logic             stall,
    input  logic             rd_rdy,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat
);

    logic             pri_vld;
    logic             ovf_vld;
    logic [WIDTH-1:0] pri_dat;
    logic [WIDTH-1:0] ovf_dat;
    logic             xfer;
    logic             wr_fire;

    // Ready depends only on registered state, so no downstream signal reaches
    // the upstream handshake combinationally.
    assign wr_rdy  = !ovf_vld;
    assign wr_fire = wr_vld & wr_rdy;

    // The overflow entry always holds the older beat when both are occupied.
    assign rd_vld = (pri_vld | ovf_vld) & !stall;
    assign rd_dat = ovf_vld ? ovf_dat : pri_dat;
    assign xfer   = rd_vld & rd_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            pri_vld <= 1'b0;
            ovf_vld <= 1'b0;
            pri_dat <= '0;
            ovf_dat <= '0;
        end else if (ovf_vld) begin
            // Primary is frozen while the overflow drains; no writes accepted.
            if (xfer) begin
                ovf_vld <= 1'b0;
            end
        end else begin
            // Primary is the output: it is either consumed or parked in the
            // overflow, so it always reloads from this cycle's write.
            pri_vld <= wr_fire;
            if (wr_fire) begin
                pri_dat <= wr_dat;
            end
            if (!xfer) begin
                ovf_vld <= pri_vld;
                if (pri_vld) begin
                    ovf_dat <= pri_dat;
                end
            end
        end
    end

endmodule

// File: rtl/prim_arb_rr.sv
// Purpose: round-robin arbiter muxing N requesters onto one tagged valid/ready channel.
// Latency: 1 cycle from beat accept to dvld_o (registered skid output).
// Backpressure: one not-ready cycle absorbed by the skid; req_rdy_o then all zero until drained.
// Ports: clk, reset (sync, active-high); req_vld_i/req_dat_i/req_rdy_o per requester
//        (req_last_i only when PRIM_ARB_LOCK_EN is defined); dstall_i, drdy_i, dvld_o, ddat_o, dsrc_o.
// Build option: define PRIM_ARB_LOCK_EN to hold the grant across multi-beat transactions.
module prim_arb_rr
    import prim_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 32,
    parameter int SRCW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       req_vld_i,
    input  logic [N*WIDTH-1:0] req_dat_i,
`ifdef PRIM_ARB_LOCK_EN
    input  logic [N-1:0]       req_last_i,
`endif
    output logic [N-1:0]       req_rdy_o,
    input  logic               dstall_i,
    input  logic               drdy_i,
    output logic               dvld_o,
    output logic [WIDTH-1:0]   ddat_o,
    output logic [SRCW-1:0]    dsrc_o
);

    localparam logic [SRCW-1:0] LAST_IDX = SRCW'(N - 1);

    logic [SRCW-1:0]       ptr;
    logic [SRCW-1:0]       g;
    logic [SRCW-1:0]       next_ptr;
    logic                  found;
    logic                  urdy;
    logic                  accept;
    rr_pick_t              pick;
    logic [WIDTH-1:0]      sel_dat;
    logic [WIDTH+SRCW-1:0] skid_dat;
    logic                  unused_pick_idx;

    assign pick = rr_pick(ARB_MAX_N'(req_vld_i), ARB_IDX_W'(ptr));
    // Upper index bits are always zero for N below ARB_MAX_N.
    assign unused_pick_idx = ^pick.idx;

`ifdef PRIM_ARB_LOCK_EN
    arb_state_e      state;
    logic [SRCW-1:0] lock_idx;

    always_comb begin
        g     = pick.idx[SRCW-1:0];
        found = pick.found;
        if (state == ARB_LOCKED) begin
            g     = lock_idx;
            found = req_vld_i[lock_idx];
        end
    end
`else
    assign g     = pick.idx[SRCW-1:0];
    assign found = pick.found;
`endif

    assign accept = found & urdy;

    // Explicit wrap compare keeps non-power-of-2 N correct.
    assign next_ptr = (g == LAST_IDX) ? '0 : g + SRCW'(1);

    always_comb begin
        req_rdy_o = '0;
        sel_dat   = '0;
        for (int i = 0; i < N; i++) begin
            if (SRCW'(i) == g) begin
                req_rdy_o[i] = accept;
                sel_dat      = req_dat_i[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef PRIM_ARB_LOCK_EN
    // The pointer only moves when a transaction completes, so a locked
    // requester does not also collect the next round-robin slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB_IDLE;
            lock_idx <= '0;
            ptr      <= '0;
        end else if (accept) begin
            case (state)
                ARB_IDLE: begin
                    if (!req_last_i[g]) begin
                        state    <= ARB_LOCKED;
                        lock_idx <= g;
                    end else begin
                        ptr <= next_ptr;
                    end
                end
                ARB_LOCKED: begin
                    if (req_last_i[g]) begin
                        state <= ARB_IDLE;
                        ptr   <= next_ptr;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= next_ptr;
        end
    end
`endif

    prim_fifo2 #(
        .WIDTH (WIDTH + SRCW)
    ) u_skid (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (accept),
        .wr_dat ({g, sel_dat}),
        .wr_rdy (urdy),
        .stall  (dstall_i),
        .rd_rdy (drdy_i),
        .rd_vld (dvld_o),
        .rd_dat (skid_dat)
    );

    assign {dsrc_o, ddat_o} = skid_dat;

endmodule

// File: doc/prim_arb_rr.md
# prim_arb_rr

Round-robin arbiter that shares one downstream valid/ready channel between N upstream requesters. Each accepted beat is tagged with its source index and registered into a 2-entry skid buffer, so the downstream interface has registered data and honours a stall qualifier. The block is the front end for shared consumers such as bus ports and write-back paths.

## Interface

- N, 4, number of requesters; legal range 2..16
- WIDTH, 32, payload width per beat
- SRCW, $clog2(N), source-index width; derived, not overridden

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_vld_i  in  N  per-requester beat valid
- req_dat_i  in  N×WIDTH  per-requester payload; requester i occupies bits [i*WIDTH +: WIDTH]
- req_last_i  in  N  last beat of a transaction (present only with PRIM_ARB_LOCK_EN)
- req_rdy_o  out  N  one-hot beat accept; at most one bit high
- dstall_i  in  1  downstream stall; masks dvld_o and blocks transfers
- drdy_i  in  1  downstream ready
- dvld_o  out  1  output beat valid
- ddat_o  out  WIDTH  output payload
- dsrc_o  out  SRCW  requester index of the output beat

## Operation

- Priority pointer ptr (SRCW bits). Requesters are scanned in the order ptr, ptr+1, …, N-1, 0, …, ptr-1. The first requester with req_vld_i set is granted (g).
- Skid input ready: urdy = !skid_full.
- req_rdy_o[i] = (i == g) & req_vld_i[g] & urdy, driven combinationally.
- Acceptance: a beat is accepted when req_vld_i[g] & req_rdy_o[g]. The accepted beat is written into the skid buffer as {g, req_dat_i[g]}.
- Pointer update: after an accepted beat, ptr <= (g+1) mod N. Wrap at N-1 uses an explicit compare, so non-power-of-2 N is legal.
- The arbitration decision uses no dvld_o/drdy_i combinational path. The only path from downstream to req_rdy_o is through registered skid state.
- Skid buffer:
  - 2 entries: a primary entry and an overflow entry.
  - Output comes from the overflow entry when it is occupied, otherwise from the primary entry.
  - dvld_o = entry_valid & !dstall_i.
  - Downstream transfer = dvld_o & drdy_i.
  - When downstream is not ready (drdy_i low or dstall_i high) while urdy is high, the primary entry moves to the overflow entry.
  - A transfer clears the overflow entry's valid bit.
  - skid_full = overflow valid.
- State machine (lock mode only):
  - ARB_IDLE: normal arbitration.
  - ARB_IDLE → ARB_LOCKED: on an accepted beat with req_last_i = 0. The locked index L is held.
  - ARB_LOCKED: g is forced to L and all other requesters are ignored.
  - ARB_LOCKED → ARB_IDLE: on an accepted beat from L with req_last_i = 1. At that point ptr <= (L+1) mod N.
  - In ARB_LOCKED, ptr does not advance.
- Reset values:
  - ptr = 0, state ARB_IDLE, both skid entries invalid.
  - dvld_o = 0. ddat_o = 0 and dsrc_o = 0 (entry data cleared).
  - req_rdy_o is high only where req_vld_i is high.

## Timing

- Latency: a beat accepted in cycle t drives dvld_o in cycle t+1, provided dstall_i is low.
- Throughput: 1 beat per cycle sustained when drdy_i = 1 and dstall_i = 0.
- Backpressure: one cycle of downstream not ready is absorbed by the overflow entry. In the following cycle, req_rdy_o is all zero until the overflow entry drains.
- dstall_i high: dvld_o is 0 in that cycle, no transfer happens, and the data held in the entries is preserved.
- Simultaneous accept and transfer in the same cycle: legal, with no bubble.
- All requests valid: each requester receives exactly one beat per N accepted beats (non-lock mode).
- Reset asserted mid-transaction: both entries are discarded and the lock is released next cycle. No beat is emitted after reset.

## Configuration

- PRIM_ARB_LOCK_EN defined:
  - The req_last_i port and the ARB_IDLE/ARB_LOCKED machine exist.
  - Multi-beat transactions are never interleaved.
- PRIM_ARB_LOCK_EN undefined:
  - There is no req_last_i port.
  - Every beat arbitrates independently and the pointer advances after every accepted beat.

## Structure

- Package prim_arb_pkg holds:
  - arb_state_e {ARB_IDLE, ARB_LOCKED}.
  - Function rr_pick(req, ptr), which returns a grant index and a found flag and is shared by future arbiters.
  - Constant ARB_MAX_N = 16.
- Sub-module: prim_fifo2 instantiated as the skid stage, with WIDTH+SRCW payload, urdy feeding the arbiter and the downstream ports passed through.
- Arbitration logic, pointer and lock FSM live in prim_arb_rr.

## Test plan

- Single requester: N=4, only req 2 valid with data 0xA5 → req_rdy_o = 0100. Next cycle: dvld_o = 1, ddat_o = 0xA5, dsrc_o = 2. Then ptr = 3.
- All-valid fairness: all 4 requesters valid for 8 cycles, drdy_i = 1 → dsrc_o sequence is 0,1,2,3,0,1,2,3, with no bubbles.
- Backpressure:
  - Stimulus: drdy_i low for 3 cycles during streaming.
  - Required: exactly one beat is absorbed and req_rdy_o is then 0000.
  - Required after drdy_i rises: no beat is lost or duplicated, and order is preserved.
- Stall: dstall_i high with a valid entry → dvld_o = 0 and data is held. When dstall_i is released, the same ddat_o and dsrc_o are presented.
- Lock (PRIM_ARB_LOCK_EN): req 1 sends 3 beats with last on beat 3 while req 0 and req 2 are valid → dsrc_o = 1,1,1, then 2. ptr = 2 after the last beat is accepted.
- Reset mid-transaction: assert reset while locked with both entries valid → next cycle dvld_o = 0, ptr = 0 and state is ARB_IDLE.
